dlatch_checker: RTL and testbench
=================================

// Module: dlatch_checker
// PURPOSE
//  Synthesizable response checker for the d_latch block, and the receive-side counterpart of the
//  latch stimulus bench. It samples the latch inputs (d, en, dut_rstn) and output (q) on every clk
//  edge and runs an internal reference model of the latch. Persistent mismatches are reported as
//  errors, together with saturating statistics. It sits next to the DUT in self-checking benches
//  and on-board test harnesses.
// PARAMETERS
//  CNT_W        16  width of every statistics counter and of first_err
//  SETTLE       1   extra consecutive mismatching samples tolerated before an error is counted
//                   (0 = count an error on the first mismatching sample)
//  STOP_ON_ERR  0   1 = enter HALT on the first counted error; 0 = keep checking
// PORTS
//  clk        in   1      checker clock; all state updates on its rising edge
//  rstn       in   1      asynchronous active-low reset of the checker
//  start      in   1      1-cycle pulse: clear statistics and begin checking
//  stop       in   1      1-cycle pulse: return to IDLE; statistics hold
//  dut_rstn   in   1      reset seen by the latch (observed, not driven)
//  en         in   1      latch enable (observed)
//  d          in   1      latch data (observed)
//  q          in   1      latch output (observed)
//  busy       out  1      1 while in CHECK
//  err        out  1      1-cycle pulse on each counted error
//  err_flag   out  1      sticky; set on the first counted error; cleared only by start or rstn
//  mis_cnt    out  CNT_W  number of counted errors, saturating
//  smp_cnt    out  CNT_W  number of samples taken in CHECK, saturating
//  first_err  out  CNT_W  smp_cnt value at the first counted error
//  tog_cnt    out  CNT_W  number of en transitions seen in CHECK, saturating
// BEHAVIOUR
//  - rstn=0 (async, any time, including mid-check): state=IDLE; exp_q=0; persistence count pcnt=0;
//    every output 0. Checking resumes only after a new start.
//  - FSM states IDLE, CHECK, HALT:
//    - IDLE -start-> CHECK
//    - CHECK -stop-> IDLE
//    - CHECK -(counted error and STOP_ON_ERR=1)-> HALT
//    - HALT -start-> CHECK; HALT -stop-> IDLE
//    - start in CHECK restarts the check (clear, stay in CHECK).
//    - start and stop in the same cycle: start wins.
//  - On the start edge: clear mis_cnt, smp_cnt, first_err, tog_cnt, err_flag and pcnt; exp_q=0;
//    en_prev=en. The start cycle itself is not a sample.
//  - Reference model, evaluated each CHECK cycle:
//    exp_now = !dut_rstn ? 0 : (en ? d : exp_q); exp_q <= exp_now.
//  - Mismatch: mm = (q != exp_now). mm=1 -> pcnt++ (saturating at SETTLE+1); mm=0 -> pcnt=0.
//  - Counted error: on the cycle in which mm=1 and pcnt==SETTLE. It fires exactly once per
//    mismatch run; a run must end with a match before the next error can be counted.
//    On a counted error: err=1 for that cycle; mis_cnt++; err_flag=1; if err_flag was 0,
//    first_err <= smp_cnt (the pre-increment value).
//  - smp_cnt increments every CHECK cycle. tog_cnt increments when en != en_prev; en_prev <= en.
//  - Every counter saturates at all-ones and never wraps.
//  - IDLE and HALT: no sampling, all counters hold, err=0, busy=0.
//  - Latency: err and the counter updates are registered and visible 1 clk after the sample edge.
// TESTING
//  1 rstn low 2 clk, then high -> all outputs 0, busy=0; start pulse -> busy=1 on the next cycle.
//  2 Ideal latch model on q; en toggles 5 times with d=i (i=0..4) over 50 clk ->
//    mis_cnt=0, err_flag=0, tog_cnt=5, smp_cnt=50.
//  3 SETTLE=1; force q inverted for 1 sample -> no error; for 3 consecutive samples ->
//    err pulses once, mis_cnt=1, first_err = sample index of the 2nd bad sample.
//  4 STOP_ON_ERR=1; force a stuck-at-0 q with en=1, d=1 -> HALT, busy=0, counters frozen;
//    start -> all counters 0, busy=1.
//  5 dut_rstn=0 while en=1 and d=1 with q=0 -> no error (exp=0);
//    checker rstn pulsed mid-CHECK -> IDLE, all outputs 0.
//  6 Drive 2^CNT_W+3 samples (CNT_W=4) -> smp_cnt holds at 15; simultaneous start and stop -> CHECK.

Source files
------------

// File: rtl/dlatch_checker.sv
// Response checker for a d_latch: it samples the latch inputs and output on each
// clk edge and compares q against an internal reference latch. Mismatch runs that
// last longer than SETTLE extra samples are counted as errors. Saturating
// statistics are reported alongside the error flags.
module dlatch_checker #(
  parameter int CNT_W       = 16,
  parameter int SETTLE      = 1,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             dut_rstn,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  output logic             busy,
  output logic             err,
  output logic             err_flag,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] smp_cnt,
  output logic [CNT_W-1:0] first_err,
  output logic [CNT_W-1:0] tog_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_HALT
  } state_t;

  // The persistence counter only needs to reach SETTLE+1, where it parks.
  localparam int              PW       = $clog2(SETTLE + 2);
  localparam logic [PW-1:0]   P_SETTLE = PW'(SETTLE);
  localparam logic [PW-1:0]   P_MAX    = PW'(SETTLE + 1);
  localparam logic [CNT_W-1:0] C_MAX   = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             exp_q, exp_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             en_prev_q, en_prev_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] tog_q, tog_d;

  logic exp_now;
  logic mm;
  logic sample;
  logic hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Reference latch value for this sample and the counted-error condition.
  always_comb begin
    exp_now = !dut_rstn ? 1'b0 : (en ? d : exp_q);
    mm      = (q != exp_now);
    // start and stop both take priority over sampling, so their cycles are not samples.
    sample  = (state_q == S_CHECK) && !start && !stop;
    hit     = sample && mm && (pcnt_q == P_SETTLE);
  end

  // FSM next-state: start wins over stop; a counted error may halt the check.
  always_comb begin
    // NOTE: assigning a default before any branch keeps every path driven, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CHECK;
      S_CHECK: begin
        if (start)                    state_d = S_CHECK;
        else if (stop)                state_d = S_IDLE;
        else if (hit && STOP_ON_ERR)  state_d = S_HALT;
      end
      S_HALT: begin
        if (start)     state_d = S_CHECK;
        else if (stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: clear on start, update model and statistics on each sample.
  always_comb begin
    exp_d      = exp_q;
    pcnt_d     = pcnt_q;
    en_prev_d  = en_prev_q;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    mis_d      = mis_q;
    smp_d      = smp_q;
    first_d    = first_q;
    tog_d      = tog_q;
    if (start) begin
      exp_d      = 1'b0;
      pcnt_d     = '0;
      en_prev_d  = en;
      err_flag_d = 1'b0;
      mis_d      = '0;
      smp_d      = '0;
      first_d    = '0;
      tog_d      = '0;
    end else if (sample) begin
      exp_d  = exp_now;
      if (mm) pcnt_d = (pcnt_q == P_MAX) ? pcnt_q : pcnt_q + PW'(1);
      else    pcnt_d = '0;
      if (hit) begin
        err_d      = 1'b1;
        mis_d      = sat_inc(mis_q);
        err_flag_d = 1'b1;
        if (!err_flag_q) first_d = smp_q;
      end
      smp_d = sat_inc(smp_q);
      if (en != en_prev_q) tog_d = sat_inc(tog_q);
      en_prev_d = en;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath registers; all cleared asynchronously so outputs read 0 during reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_q      <= 1'b0;
      pcnt_q     <= '0;
      en_prev_q  <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      mis_q      <= '0;
      smp_q      <= '0;
      first_q    <= '0;
      tog_q      <= '0;
    end else begin
      exp_q      <= exp_d;
      pcnt_q     <= pcnt_d;
      en_prev_q  <= en_prev_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      mis_q      <= mis_d;
      smp_q      <= smp_d;
      first_q    <= first_d;
      tog_q      <= tog_d;
    end
  end

  assign busy      = (state_q == S_CHECK);
  assign err       = err_q;
  assign err_flag  = err_flag_q;
  assign mis_cnt   = mis_q;
  assign smp_cnt   = smp_q;
  assign first_err = first_q;
  assign tog_cnt   = tog_q;

endmodule

// File: tb/tb_dlatch_checker.sv
// Bench for dlatch_checker: two instances share one stimulus stream, one with
// wide counters that keeps checking, one with 4-bit counters, SETTLE=0 and
// halt-on-error. Both are compared every cycle against a behavioural model.
module tb_dlatch_checker;

  logic clk = 1'b0;
  logic rstn, start, stop, dut_rstn, en, d, q;

  logic        a_busy, a_err, a_flag;
  logic [15:0] a_mis, a_smp, a_first, a_tog;
  logic        b_busy, b_err, b_flag;
  logic [3:0]  b_mis, b_smp, b_first, b_tog;

  int n_tests = 0;
  int n_fail  = 0;
  bit lat     = 1'b0;
  int a_err_seen;

  always #5 clk = ~clk;

  dlatch_checker #(.CNT_W(16), .SETTLE(1), .STOP_ON_ERR(1'b0)) u_a (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .dut_rstn(dut_rstn),
    .en(en), .d(d), .q(q), .busy(a_busy), .err(a_err), .err_flag(a_flag),
    .mis_cnt(a_mis), .smp_cnt(a_smp), .first_err(a_first), .tog_cnt(a_tog)
  );

  dlatch_checker #(.CNT_W(4), .SETTLE(0), .STOP_ON_ERR(1'b1)) u_b (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .dut_rstn(dut_rstn),
    .en(en), .d(d), .q(q), .busy(b_busy), .err(b_err), .err_flag(b_flag),
    .mis_cnt(b_mis), .smp_cnt(b_smp), .first_err(b_first), .tog_cnt(b_tog)
  );

  // Model: mode 0 idle, 1 checking, 2 halted. 'run' is the plain length of the
  // current mismatch run; an error is counted when it reaches settle+1.
  localparam int M_IDLE = 0, M_CHK = 1, M_HALT = 2;
  typedef struct {
    int mode;
    bit ex;
    int run;
    bit ep;
    int mis, smp, fe, tog;
    bit flag, err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t m;
    m.mode = M_IDLE; m.ex = 0; m.run = 0; m.ep = 0;
    m.mis = 0; m.smp = 0; m.fe = 0; m.tog = 0; m.flag = 0; m.err = 0;
    return m;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v + 1 > maxv) ? maxv : v + 1;
  endfunction

  function automatic mdl_t step(input mdl_t m, input bit st, input bit sp, input bit dr,
                                input bit e, input bit dd, input bit qq,
                                input int settle, input bit soe, input int maxv);
    bit want;
    m.err = 0;
    if (st) begin
      m.mode = M_CHK; m.ex = 0; m.run = 0; m.ep = e;
      m.mis = 0; m.smp = 0; m.fe = 0; m.tog = 0; m.flag = 0;
    end else if (sp) begin
      m.mode = M_IDLE;
    end else if (m.mode == M_CHK) begin
      want = dr ? (e ? dd : m.ex) : 1'b0;
      m.run = (qq != want) ? m.run + 1 : 0;
      if (m.run == settle + 1) begin
        m.err = 1;
        m.mis = sat(m.mis, maxv);
        if (!m.flag) m.fe = m.smp;
        m.flag = 1;
        if (soe) m.mode = M_HALT;
      end
      m.smp = sat(m.smp, maxv);
      if (e != m.ep) m.tog = sat(m.tog, maxv);
      m.ep = e;
      m.ex = want;
    end
    return m;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    cmp("a_busy",  32'(a_busy),  32'(ma.mode == M_CHK));
    cmp("a_err",   32'(a_err),   32'(ma.err));
    cmp("a_flag",  32'(a_flag),  32'(ma.flag));
    cmp("a_mis",   32'(a_mis),   32'(ma.mis));
    cmp("a_smp",   32'(a_smp),   32'(ma.smp));
    cmp("a_first", 32'(a_first), 32'(ma.fe));
    cmp("a_tog",   32'(a_tog),   32'(ma.tog));
    cmp("b_busy",  32'(b_busy),  32'(mb.mode == M_CHK));
    cmp("b_err",   32'(b_err),   32'(mb.err));
    cmp("b_flag",  32'(b_flag),  32'(mb.flag));
    cmp("b_mis",   32'(b_mis),   32'(mb.mis));
    cmp("b_smp",   32'(b_smp),   32'(mb.smp));
    cmp("b_first", 32'(b_first), 32'(mb.fe));
    cmp("b_tog",   32'(b_tog),   32'(mb.tog));
  endtask

  // One clock: apply start/stop and q (ideal latch, optionally inverted), advance
  // the models, then sample just after the edge.
  task automatic cyc(input bit st, input bit sp, input bit inv);
    lat   = !dut_rstn ? 1'b0 : (en ? d : lat);
    q     = lat ^ inv;
    start = st;
    stop  = sp;
    if (!rstn) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = step(ma, st, sp, dut_rstn, en, d, q, 1, 1'b0, 65535);
      mb = step(mb, st, sp, dut_rstn, en, d, q, 0, 1'b1, 15);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rnd_ed();
    en = 1'($urandom_range(0, 1));
    d  = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; dut_rstn = 1'b0;
    en = 1'b0; d = 1'b0; q = 1'b0;
    ma = mreset(); mb = mreset();

    // Reset for two clocks, then release: all outputs zero, not busy.
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rstn = 1'b1;
    cyc(0, 0, 0);
    cmp("t1_idle_busy", 32'(a_busy), 32'd0);
    dut_rstn = 1'b1;
    cyc(1, 0, 0);
    cmp("t1_start_busy", 32'(a_busy), 32'd1);

    // Ideal latch, five en toggles with d following the segment index, 50 samples.
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 5) begin
        en = ~en;
        d  = 1'(i / 10);
      end
      cyc(0, 0, 0);
    end
    cmp("t2_mis", 32'(a_mis), 32'd0);
    cmp("t2_flag", 32'(a_flag), 32'd0);
    cmp("t2_tog", 32'(a_tog), 32'd5);
    cmp("t2_smp", 32'(a_smp), 32'd50);

    // Settle window: one inverted sample is tolerated, three consecutive count once.
    cyc(1, 0, 0);
    a_err_seen = 0;
    for (int i = 0; i < 13; i++) begin
      rnd_ed();
      cyc(0, 0, (i == 4) || (i >= 8 && i <= 10));
      if (a_err) a_err_seen++;
    end
    cmp("t3_err_pulses", 32'(a_err_seen), 32'd1);
    cmp("t3_mis", 32'(a_mis), 32'd1);
    cmp("t3_first", 32'(a_first), 32'd9);
    cmp("t3_flag", 32'(a_flag), 32'd1);

    // Stuck-at-0 q with en=1, d=1: the halting instance freezes after one sample.
    en = 1'b1; d = 1'b1;
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    cmp("t4_halt_busy", 32'(b_busy), 32'd0);
    cmp("t4_halt_smp", 32'(b_smp), 32'd1);
    cmp("t4_halt_mis", 32'(b_mis), 32'd1);
    cyc(1, 0, 0);
    cmp("t4_restart_busy", 32'(b_busy), 32'd1);
    cmp("t4_restart_smp", 32'(b_smp), 32'd0);
    cmp("t4_restart_mis", 32'(b_mis), 32'd0);
    cmp("t4_restart_flag", 32'(b_flag), 32'd0);

    // Latch held in reset while en=1, d=1 and q=0: no error expected.
    dut_rstn = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    cmp("t5_dutrst_mis_a", 32'(a_mis), 32'd0);
    cmp("t5_dutrst_mis_b", 32'(b_mis), 32'd0);

    // Checker reset mid-check takes effect without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    ma = mreset(); mb = mreset();
    compare_all();
    cmp("t5_rst_busy", 32'(a_busy), 32'd0);
    cmp("t5_rst_smp", 32'(a_smp), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_ed();
      cyc(0, 0, 0);
    end
    cmp("t5_stays_idle", 32'(a_busy), 32'd0);

    // Saturation of the 4-bit sample counter, then start+stop together.
    dut_rstn = 1'b1;
    cyc(1, 0, 0);
    for (int i = 0; i < 19; i++) begin
      rnd_ed();
      cyc(0, 0, 0);
    end
    cmp("t6_sat_b", 32'(b_smp), 32'd15);
    cmp("t6_count_a", 32'(a_smp), 32'd19);
    cyc(1, 1, 0);
    cmp("t6_startstop_a", 32'(a_busy), 32'd1);
    cmp("t6_startstop_b", 32'(b_busy), 32'd1);
    cmp("t6_startstop_smp", 32'(a_smp), 32'd0);

    // Random traffic: latch resets, bursts of bad q, occasional start/stop.
    for (int i = 0; i < 400; i++) begin
      rnd_ed();
      dut_rstn = ($urandom_range(0, 9) != 0);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
